soc_ahb3_sram_slave: RTL and testbench

//  AHB3-Lite responder: on-chip SRAM target for one slave port of the AHB3 bus interconnect.

---
 rtl/soc_ahb3_sram_slave.sv | 167 ++++++++++++++++
 tb/tb_soc_ahb3_sram_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_ahb3_sram_slave.sv
// rtl/soc_ahb3_sram_slave.sv - AHB3-Lite SRAM responder with wait states, two-cycle ERROR and write-to-read forwarding
module soc_ahb3_sram_slave #(
    parameter int XLEN        = 32,
    parameter int PLEN        = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_hsel_i,
    input  logic [PLEN-1:0]   s_haddr_i,
    input  logic [XLEN-1:0]   s_hwdata_i,
    input  logic              s_hwrite_i,
    input  logic [2:0]        s_hsize_i,
    input  logic [2:0]        s_hburst_i,
    input  logic [XLEN/8-1:0] s_hprot_i,
    input  logic [1:0]        s_htrans_i,
    input  logic              s_hmastlock_i,
    input  logic              s_hready_i,
    output logic [XLEN-1:0]   s_hrdata_o,
    output logic              s_hreadyout_o,
    output logic              s_hresp_o
);

    localparam int SW  = XLEN / 8;
    localparam int SWB = $clog2(SW);
    localparam int DW  = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   idx_q;
    logic [SWB-1:0]  off_q;
    logic            write_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] hrdata_q;
    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            acc_err;
    logic [DW-1:0]   acc_idx;
    logic [SWB-1:0]  acc_off;
    logic            wr_en;
    logic [SW-1:0]   wr_be;
    logic            load_rd;
    logic [DW-1:0]   rd_idx;
    logic [XLEN-1:0] rd_word;

    // Bits the responder deliberately ignores: burst/prot/lock and aliased upper address bits.
    logic unused_inputs;
    assign unused_inputs = ^{s_hburst_i, s_hprot_i, s_hmastlock_i, s_haddr_i[PLEN-1:SWB+DW]};

    function automatic logic size_err(input logic [2:0] size, input logic [SWB-1:0] off);
        logic e;
        e = (int'(size) > SWB);
        for (int i = 0; i < SWB; i++) begin
            if (i < int'(size) && off[i]) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [SW-1:0] byte_en(input logic [2:0] size, input logic [SWB-1:0] off);
        logic [SW-1:0] be;
        be = '0;
        for (int i = 0; i < SW; i++) begin
            if (i >= int'(off) && i < int'(off) + (1 << size)) be[i] = 1'b1;
        end
        return be;
    endfunction

    assign s_hreadyout_o = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    assign s_hresp_o     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign s_hrdata_o    = hrdata_q;

    // Only sample a new address phase while our own data phase is not being extended.
    assign accept  = s_hsel_i && s_hready_i && s_htrans_i[1] && s_hreadyout_o;
    assign acc_idx = s_haddr_i[SWB +: DW];
    assign acc_off = s_haddr_i[SWB-1:0];
    assign acc_err = size_err(s_hsize_i, acc_off);

    assign wr_en = (state_q == ST_LAST) && write_q;
    assign wr_be = byte_en(size_q, off_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_rd = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_LAST;
                        load_rd = !s_hwrite_i;
                        rd_idx  = acc_idx;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_LAST;
                    load_rd = !write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // A write retiring on the same edge as a read load supplies its bytes directly.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_en && (idx_q == rd_idx)) begin
            for (int i = 0; i < SW; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = s_hwdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            off_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= acc_idx;
                off_q   <= acc_off;
                write_q <= s_hwrite_i;
                size_q  <= s_hsize_i;
            end
            if (load_rd) hrdata_q <= rd_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < SW; i++) begin
                if (wr_be[i]) mem[idx_q][8*i +: 8] <= s_hwdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_soc_ahb3_sram_slave.sv
// tb/tb_soc_ahb3_sram_slave.sv - scoreboard bench for soc_ahb3_sram_slave at 0, 2 and 3 wait states
module tb_soc_ahb3_sram_slave;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] edata;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        force_lo;
    logic [1:0]  sel;
    logic [2:0]  hsel_v;
    logic        bus_ready;
    logic [31:0] rdata [3];
    logic        rdy [3];
    logic        resp [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ws_of [3] = '{0, 2, 3};
    logic [31:0] model [int];
    xfer_t       seq [$];
    xfer_t       exp_q [$];

    assign hsel_v[0] = hsel && (sel == 2'd0);
    assign hsel_v[1] = hsel && (sel == 2'd1);
    assign hsel_v[2] = hsel && (sel == 2'd2);
    assign bus_ready = force_lo ? 1'b0 : rdy[sel];

    soc_ahb3_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_ni(rst_n), .s_hsel_i(hsel_v[0]), .s_haddr_i(haddr),
        .s_hwdata_i(hwdata), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(3'd0),
        .s_hprot_i(4'd0), .s_htrans_i(htrans), .s_hmastlock_i(1'b0), .s_hready_i(bus_ready),
        .s_hrdata_o(rdata[0]), .s_hreadyout_o(rdy[0]), .s_hresp_o(resp[0])
    );

    soc_ahb3_sram_slave #(.WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_ni(rst_n), .s_hsel_i(hsel_v[1]), .s_haddr_i(haddr),
        .s_hwdata_i(hwdata), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(3'd0),
        .s_hprot_i(4'd0), .s_htrans_i(htrans), .s_hmastlock_i(1'b0), .s_hready_i(bus_ready),
        .s_hrdata_o(rdata[1]), .s_hreadyout_o(rdy[1]), .s_hresp_o(resp[1])
    );

    soc_ahb3_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_ni(rst_n), .s_hsel_i(hsel_v[2]), .s_haddr_i(haddr),
        .s_hwdata_i(hwdata), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(3'd0),
        .s_hprot_i(4'd0), .s_htrans_i(htrans), .s_hmastlock_i(1'b0), .s_hready_i(bus_ready),
        .s_hrdata_o(rdata[2]), .s_hreadyout_o(rdy[2]), .s_hresp_o(resp[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] d);
        xfer_t x;
        x.wr    = wr;
        x.addr  = a;
        x.size  = sz;
        x.wdata = d;
        x.err   = (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
        x.edata = 32'h0;
        return x;
    endfunction

    // Reference memory: writes land when accepted, reads capture the word as it stands then.
    task automatic push_exp(input xfer_t x);
        int          key;
        logic [31:0] w;
        key = int'(sel) * 65536 + int'(x.addr[11:2]);
        w   = model.exists(key) ? model[key] : 32'h0;
        if (x.wr && !x.err) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= int'(x.addr[1:0]) && b < int'(x.addr[1:0]) + (1 << int'(x.size)))
                    w[8*b +: 8] = x.wdata[8*b +: 8];
            end
            model[key] = w;
        end
        x.edata = w;
        exp_q.push_back(x);
    endtask

    task automatic run_seq();
        int    i;
        int    cyc;
        int    waits;
        logic  r;
        logic  acc;
        xfer_t cur;
        i = 0;
        cyc = 0;
        waits = 0;
        exp_q.delete();
        while ((i < seq.size() || exp_q.size() != 0) && cyc < 200) begin
            hsel = 1'b1;
            if (i < seq.size()) begin
                htrans = 2'b10;
                haddr  = seq[i].addr;
                hwrite = seq[i].wr;
                hsize  = seq[i].size;
            end else begin
                htrans = 2'b00;
            end
            hwdata = (exp_q.size() != 0 && exp_q[0].wr) ? exp_q[0].wdata : 32'h0;
            @(negedge clk);
            r = bus_ready;
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                if (!r) begin
                    waits++;
                    n_cmp++;
                    if (resp[sel] !== cur.err) begin
                        n_bad++;
                        $display("FAIL wait_resp @%h: got %b expected %b", cur.addr, resp[sel], cur.err);
                    end
                end else begin
                    n_cmp++;
                    if (resp[sel] !== cur.err) begin
                        n_bad++;
                        $display("FAIL done_resp @%h: got %b expected %b", cur.addr, resp[sel], cur.err);
                    end
                    n_cmp++;
                    if (waits !== (cur.err ? 1 : ws_of[sel])) begin
                        n_bad++;
                        $display("FAIL wait_count @%h: got %0d expected %0d", cur.addr, waits,
                                 cur.err ? 1 : ws_of[sel]);
                    end
                    if (!cur.wr && !cur.err) begin
                        n_cmp++;
                        if (rdata[sel] !== cur.edata) begin
                            n_bad++;
                            $display("FAIL rdata @%h: got %h expected %h", cur.addr, rdata[sel], cur.edata);
                        end
                    end
                    void'(exp_q.pop_front());
                    waits = 0;
                end
            end
            acc = r && (i < seq.size());
            @(posedge clk);
            #1;
            if (acc) begin
                push_exp(seq[i]);
                i++;
            end
            cyc++;
        end
        htrans = 2'b00;
        hwdata = 32'h0;
        n_cmp++;
        if (cyc >= 200) begin
            n_bad++;
            $display("FAIL seq_timeout: got %0d cycles expected < 200", cyc);
        end
        seq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rdy[k] !== 1'b1 || resp[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got rdy=%b resp=%b rdata=%h expected 1 0 00000000",
                         k, rdy[k], resp[k], rdata[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forwarding();
        sel = 2'd0;
        seq.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        seq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        run_seq();
    endtask

    task automatic test_byte_write();
        sel = 2'd0;
        seq.push_back(mk(1'b1, 32'h20, 3'd2, 32'h11223344));
        seq.push_back(mk(1'b1, 32'h23, 3'd0, 32'hAB000000));
        seq.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
        seq.push_back(mk(1'b1, 32'h26, 3'd1, 32'h5A5A0000));
        seq.push_back(mk(1'b0, 32'h24, 3'd2, 32'h0));
        run_seq();
    endtask

    task automatic test_error();
        sel = 2'd0;
        seq.push_back(mk(1'b1, 32'h00, 3'd2, 32'h55AA55AA));
        seq.push_back(mk(1'b1, 32'h01, 3'd1, 32'h12341234));
        seq.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0));
        seq.push_back(mk(1'b1, 32'h00, 3'd3, 32'hFFFFFFFF));
        seq.push_back(mk(1'b0, 32'h02, 3'd2, 32'h0));
        seq.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0));
        run_seq();
    endtask

    task automatic test_back_to_back_ws2();
        sel = 2'd1;
        seq.push_back(mk(1'b1, 32'h40, 3'd2, 32'hA5A50F0F));
        seq.push_back(mk(1'b1, 32'h44, 3'd2, 32'h01020304));
        seq.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
        seq.push_back(mk(1'b0, 32'h44, 3'd2, 32'h0));
        run_seq();
    endtask

    task automatic test_hready_low();
        sel = 2'd0;
        seq.push_back(mk(1'b1, 32'h30, 3'd2, 32'h0BADF00D));
        run_seq();
        hsel     = 1'b1;
        htrans   = 2'b10;
        haddr    = 32'h30;
        hwrite   = 1'b1;
        hsize    = 3'd2;
        force_lo = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL hready_low_rdy: got %b expected 1", rdy[0]);
        end
        @(posedge clk);
        #1;
        force_lo = 1'b0;
        htrans   = 2'b00;
        hwdata   = 32'hFFFFFFFF;
        @(negedge clk);
        n_cmp++;
        if (rdy[0] !== 1'b1 || resp[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL hready_low_after: got rdy=%b resp=%b expected 1 0", rdy[0], resp[0]);
        end
        @(posedge clk);
        #1;
        hwdata = 32'h0;
        seq.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0));
        run_seq();
    endtask

    task automatic test_reset_mid_phase();
        sel = 2'd2;
        seq.push_back(mk(1'b1, 32'h50, 3'd2, 32'h12345678));
        seq.push_back(mk(1'b0, 32'h50, 3'd2, 32'h0));
        run_seq();
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = 32'h50;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++;
        if (rdy[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_wait_rdy: got %b expected 0", rdy[2]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rdy[2] !== 1'b1 || resp[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b resp=%b rdata=%h expected 1 0 00000000",
                     rdy[2], resp[2], rdata[2]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hwdata = 32'h0;
        seq.push_back(mk(1'b0, 32'h50, 3'd2, 32'h0));
        run_seq();
    endtask

    initial begin
        hsel     = 1'b0;
        haddr    = 32'h0;
        hwdata   = 32'h0;
        hwrite   = 1'b0;
        hsize    = 3'd0;
        htrans   = 2'b00;
        force_lo = 1'b0;
        sel      = 2'd0;
        rst_n    = 1'b0;
        test_reset();
        test_forwarding();
        test_byte_write();
        test_error();
        test_back_to_back_ws2();
        test_hready_low();
        test_reset_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
